// File: rtl/reconstructor_segmentado_pkg.sv
// Shared types for the segmented divider datapath: pipeline depth helper and the
// width-parameterised stage record used by the reconstructor (RECON_STAGE_T macro).
`ifndef RECON_STAGE_T
`define RECON_STAGE_T(W) struct packed { \
  logic               valid;             \
  logic               sign_coc;          \
  logic               sign_den;          \
  logic [(W)-1:0]     mag_coc;           \
  logic [(W)-1:0]     mag_den;           \
  logic [2*(W)-1:0]   res_ext;           \
  logic [2*(W)-1:0]   accu;              \
}
`endif

package divisor_pkg;

  // Stages after the input sample: capture + one per operand bit + sign/add.
  function automatic int etapas_f(input int tamanyo);
    return tamanyo + 2;
  endfunction

  typedef `RECON_STAGE_T(32) recon_stage_t;

endpackage

// File: rtl/reconstructor_segmentado_bit.sv
// One registered shift-add stage: adds |Coc| << BIT into the accumulator when bit BIT
// of |Den| is set; every other field passes straight through.
module recon_bit_stage #(
  parameter int  tamanyo = 32,
  parameter int  BIT     = 0,
  parameter type stage_t = logic
) (
  input  logic   CLK,
  input  logic   RSTa,
  input  stage_t d,
  output stage_t q
);

  logic [2*tamanyo-1:0] addend;

  assign addend = {{tamanyo{1'b0}}, d.mag_coc} << BIT;

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      q <= '0;
    end else begin
      q <= d;
      if (d.mag_den[BIT]) q.accu <= d.accu + addend;
    end
  end

endmodule

// File: rtl/reconstructor_segmentado.sv
// Pipelined signed multiply-add Num = Coc*Den + Res, one issue per clock, FIN etapas edges after START.
// Defining RECON_OVF_CHECK_EN adds the OVF port (Num outside tamanyo-bit signed range).
module reconstructor_segmentado
  import divisor_pkg::*;
#(
  parameter int tamanyo = 32
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   START,
  input  logic [tamanyo-1:0]     Coc,
  input  logic [tamanyo-1:0]     Den,
  input  logic [tamanyo-1:0]     Res,
  output logic                   FIN,
  output logic [2*tamanyo-1:0]   Num
`ifdef RECON_OVF_CHECK_EN
  ,
  output logic                   OVF
`endif
);

  localparam int etapas = etapas_f(tamanyo);
  localparam int w2     = 2 * tamanyo;

  typedef `RECON_STAGE_T(tamanyo) stage_t;

  logic               start_q;
  logic [tamanyo-1:0] coc_q;
  logic [tamanyo-1:0] den_q;
  logic [tamanyo-1:0] res_q;
  stage_t             cap_q;
  stage_t             pipe [0:etapas-2];
  stage_t             last;
  logic [w2-1:0]      prod;
  logic [w2-1:0]      sum;

  // Operands are registered on the START edge; negation happens one stage later.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      start_q <= 1'b0;
      coc_q   <= '0;
      den_q   <= '0;
      res_q   <= '0;
    end else begin
      start_q <= START;
      if (START) begin
        coc_q <= Coc;
        den_q <= Den;
        res_q <= Res;
      end
    end
  end

  // Capture: signs, unsigned magnitudes (2^(tamanyo-1) fits exactly), sign-extended addend.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      cap_q <= '0;
    end else begin
      cap_q.valid    <= start_q;
      cap_q.sign_coc <= coc_q[tamanyo-1];
      cap_q.sign_den <= den_q[tamanyo-1];
      cap_q.mag_coc  <= coc_q[tamanyo-1] ? (~coc_q + tamanyo'(1)) : coc_q;
      cap_q.mag_den  <= den_q[tamanyo-1] ? (~den_q + tamanyo'(1)) : den_q;
      cap_q.res_ext  <= {{tamanyo{res_q[tamanyo-1]}}, res_q};
      cap_q.accu     <= '0;
    end
  end

  assign pipe[0] = cap_q;

  for (genvar i = 0; i < tamanyo; i++) begin : g_bit
    recon_bit_stage #(
      .tamanyo (tamanyo),
      .BIT     (i),
      .stage_t (stage_t)
    ) u_bit (
      .CLK  (CLK),
      .RSTa (RSTa),
      .d    (pipe[i]),
      .q    (pipe[i+1])
    );
  end

  assign last = pipe[etapas-2];

  always_comb begin
    prod = last.accu;
    if (last.sign_coc ^ last.sign_den) prod = ~last.accu + w2'(1);
    sum = prod + last.res_ext;
  end

  // Num and OVF only load on a valid result, so they hold through bubbles.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      FIN <= 1'b0;
      Num <= '0;
    end else begin
      FIN <= last.valid;
      if (last.valid) Num <= sum;
    end
  end

`ifdef RECON_OVF_CHECK_EN
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      OVF <= 1'b0;
    end else if (last.valid) begin
      OVF <= ~((&sum[w2-1:tamanyo-1]) | ~(|sum[w2-1:tamanyo-1]));
    end
  end
`endif

endmodule

// File: tb/tb_reconstructor_segmentado.sv
// Bench for reconstructor_segmentado: 8-bit and 32-bit instances, directed vectors,
// random back-to-back streams, reset flush and a divider round-trip against a behavioural model.
module tb_reconstructor_segmentado;

  logic        CLK  = 1'b0;
  logic        RSTa = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  coc8 = '0, den8 = '0, res8 = '0;
  logic        fin8;
  logic [15:0] num8;

  logic        start32 = 1'b0;
  logic [31:0] coc32 = '0, den32 = '0, res32 = '0;
  logic        fin32;
  logic [63:0] num32;

`ifdef RECON_OVF_CHECK_EN
  logic        ovf8, ovf32;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] exp8[$], obsn8[$];
  int          iss8[$], obsc8[$];
  bit          expo8[$], obso8[$];
  logic [63:0] exp32[$], obsn32[$];
  int          iss32[$], obsc32[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  reconstructor_segmentado #(.tamanyo(8)) dut8 (
    .CLK   (CLK),
    .RSTa  (RSTa),
    .START (start8),
    .Coc   (coc8),
    .Den   (den8),
    .Res   (res8),
    .FIN   (fin8),
    .Num   (num8)
`ifdef RECON_OVF_CHECK_EN
    ,
    .OVF   (ovf8)
`endif
  );

  reconstructor_segmentado #(.tamanyo(32)) dut32 (
    .CLK   (CLK),
    .RSTa  (RSTa),
    .START (start32),
    .Coc   (coc32),
    .Den   (den32),
    .Res   (res32),
    .FIN   (fin32),
    .Num   (num32)
`ifdef RECON_OVF_CHECK_EN
    ,
    .OVF   (ovf32)
`endif
  );

  // Result collectors: record every FIN pulse with its cycle stamp.
  always @(negedge CLK) begin
    if (fin8) begin
      obsn8.push_back(num8);
      obsc8.push_back(cyc);
`ifdef RECON_OVF_CHECK_EN
      obso8.push_back(ovf8);
`endif
    end
    if (fin32) begin
      obsn32.push_back(num32);
      obsc32.push_back(cyc);
    end
  end

  function automatic int model8(input logic [7:0] c, input logic [7:0] d, input logic [7:0] r);
    return int'($signed(c)) * int'($signed(d)) + int'($signed(r));
  endfunction

  function automatic longint model32(input logic [31:0] c, input logic [31:0] d, input logic [31:0] r);
    return longint'($signed(c)) * longint'($signed(d)) + longint'($signed(r));
  endfunction

  task automatic clear_q();
    exp8.delete();  obsn8.delete(); iss8.delete(); obsc8.delete();
    expo8.delete(); obso8.delete();
    exp32.delete(); obsn32.delete(); iss32.delete(); obsc32.delete();
  endtask

  task automatic issue8(input logic [7:0] c, input logic [7:0] d, input logic [7:0] r);
    @(negedge CLK);
    start8 = 1'b1; coc8 = c; den8 = d; res8 = r;
    iss8.push_back(cyc + 1);
  endtask

  task automatic issue32(input logic [31:0] c, input logic [31:0] d, input logic [31:0] r);
    @(negedge CLK);
    start32 = 1'b1; coc32 = c; den32 = d; res32 = r;
    iss32.push_back(cyc + 1);
  endtask

  task automatic idle();
    @(negedge CLK);
    start8 = 1'b0; start32 = 1'b0;
  endtask

  task automatic test_reset();
    #1 RSTa = 1'b0;
    repeat (3) @(negedge CLK);
    total++; if (fin8 !== 1'b0) begin bad++; $display("FAIL reset_fin8 got=%b want=0", fin8); end
    total++; if (num8 !== 16'h0) begin bad++; $display("FAIL reset_num8 got=%h want=0000", num8); end
    total++; if (fin32 !== 1'b0) begin bad++; $display("FAIL reset_fin32 got=%b want=0", fin32); end
    total++; if (num32 !== 64'h0) begin bad++; $display("FAIL reset_num32 got=%h want=0", num32); end
`ifdef RECON_OVF_CHECK_EN
    total++; if (ovf8 !== 1'b0) begin bad++; $display("FAIL reset_ovf8 got=%b want=0", ovf8); end
`endif
    RSTa = 1'b1;
    repeat (15) @(negedge CLK);
    total++; if (obsn8.size() != 0) begin bad++; $display("FAIL reset_idle_fin got=%0d pulses want=0", obsn8.size()); end
  endtask

  task automatic test_directed();
    logic [7:0]  tc [5] = '{8'd5, 8'hFB, 8'd5, 8'h80, 8'd0};
    logic [7:0]  td [5] = '{8'd3, 8'd3, 8'hFD, 8'h80, 8'd77};
    logic [7:0]  tr [5] = '{8'd2, 8'hFE, 8'd2, 8'd0, 8'hFD};
    logic [15:0] tw [5] = '{16'd17, 16'hFFEF, 16'hFFF3, 16'h4000, 16'hFFFD};
    bit          to [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    clear_q();
    for (int i = 0; i < 5; i++) begin
      issue8(tc[i], td[i], tr[i]);
      repeat (3) idle();
    end
    repeat (14) @(negedge CLK);
    total++;
    if (obsn8.size() != 5) begin bad++; $display("FAIL dir_count got=%0d want=5", obsn8.size()); end
    for (int i = 0; i < 5 && i < obsn8.size(); i++) begin
      total++;
      if (obsn8[i] !== tw[i]) begin bad++; $display("FAIL dir_num[%0d] got=%h want=%h", i, obsn8[i], tw[i]); end
      total++;
      if (obsc8[i] - iss8[i] != 10) begin bad++; $display("FAIL dir_latency[%0d] got=%0d want=10", i, obsc8[i] - iss8[i]); end
`ifdef RECON_OVF_CHECK_EN
      total++;
      if (obso8[i] !== to[i]) begin bad++; $display("FAIL dir_ovf[%0d] got=%b want=%b", i, obso8[i], to[i]); end
`endif
    end
    total++;
    if (fin8 !== 1'b0 || num8 !== tw[4]) begin
      bad++; $display("FAIL dir_hold got fin=%b num=%h want fin=0 num=%h", fin8, num8, tw[4]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  c, d, r;
    logic [31:0] c32, d32, r32;
    int          p;
    longint      p32;
    clear_q();
    for (int i = 0; i < 50; i++) begin
      c = 8'($urandom); d = 8'($urandom); r = 8'($urandom);
      if (i == 0) begin c = 8'h80; d = 8'h80; r = 8'h7F; end
      if (i == 1) begin d = 8'h00; end
      p = model8(c, d, r);
      exp8.push_back(p[15:0]);
      expo8.push_back(p < -128 || p > 127);
      issue8(c, d, r);
    end
    idle();
    repeat (14) @(negedge CLK);
    total++;
    if (obsn8.size() != 50) begin bad++; $display("FAIL b2b8_count got=%0d want=50", obsn8.size()); end
    for (int i = 0; i < 50 && i < obsn8.size(); i++) begin
      total++;
      if (obsn8[i] !== exp8[i]) begin bad++; $display("FAIL b2b8_num[%0d] got=%h want=%h", i, obsn8[i], exp8[i]); end
      total++;
      if (obsc8[i] - iss8[i] != 10) begin bad++; $display("FAIL b2b8_latency[%0d] got=%0d want=10", i, obsc8[i] - iss8[i]); end
`ifdef RECON_OVF_CHECK_EN
      total++;
      if (obso8[i] !== expo8[i]) begin bad++; $display("FAIL b2b8_ovf[%0d] got=%b want=%b", i, obso8[i], expo8[i]); end
`endif
    end

    for (int i = 0; i < 50; i++) begin
      c32 = $urandom; d32 = $urandom; r32 = $urandom;
      if (i == 0) begin c32 = 32'h8000_0000; d32 = 32'h8000_0000; r32 = 32'h7FFF_FFFF; end
      if (i == 1) begin c32 = 32'hFFFF_FFFF; d32 = 32'h8000_0000; r32 = 32'h8000_0000; end
      p32 = model32(c32, d32, r32);
      exp32.push_back(p32);
      issue32(c32, d32, r32);
    end
    idle();
    repeat (38) @(negedge CLK);
    total++;
    if (obsn32.size() != 50) begin bad++; $display("FAIL b2b32_count got=%0d want=50", obsn32.size()); end
    for (int i = 0; i < 50 && i < obsn32.size(); i++) begin
      total++;
      if (obsn32[i] !== exp32[i]) begin bad++; $display("FAIL b2b32_num[%0d] got=%h want=%h", i, obsn32[i], exp32[i]); end
      total++;
      if (obsc32[i] - iss32[i] != 34) begin bad++; $display("FAIL b2b32_latency[%0d] got=%0d want=34", i, obsc32[i] - iss32[i]); end
    end
  endtask

  task automatic test_reset_flush();
    clear_q();
    issue8(8'd11, 8'd13, 8'd1);
    issue8(8'hF0, 8'd7, 8'd3);
    issue8(8'd100, 8'hC0, 8'hFF);
    @(negedge CLK);
    start8 = 1'b0;
    RSTa   = 1'b0;
    @(negedge CLK);
    RSTa   = 1'b1;
    repeat (20) @(negedge CLK);
    total++;
    if (obsn8.size() != 0) begin bad++; $display("FAIL flush_fin got=%0d pulses want=0", obsn8.size()); end
    total++;
    if (num8 !== 16'h0) begin bad++; $display("FAIL flush_num got=%h want=0000", num8); end
    iss8.delete();
    issue8(8'd9, 8'hF9, 8'd4);
    idle();
    repeat (14) @(negedge CLK);
    total++;
    if (obsn8.size() != 1) begin
      bad++; $display("FAIL flush_reissue_count got=%0d want=1", obsn8.size());
    end else begin
      total++;
      if (obsn8[0] !== 16'hFFC5) begin bad++; $display("FAIL flush_reissue_num got=%h want=ffc5", obsn8[0]); end
      total++;
      if (obsc8[0] - iss8[0] != 10) begin bad++; $display("FAIL flush_reissue_latency got=%0d want=10", obsc8[0] - iss8[0]); end
    end
  endtask

  task automatic test_divider_loop();
    int n, d, q, r;
    clear_q();
    for (int i = 0; i < 1000; i++) begin
      do begin
        n = int'($urandom_range(0, 255)) - 128;
        d = int'($urandom_range(0, 255)) - 128;
      end while (d == 0 || (n == -128 && d == -1));
      q = n / d;
      r = n % d;
      exp8.push_back(n[15:0]);
      issue8(q[7:0], d[7:0], r[7:0]);
    end
    idle();
    repeat (14) @(negedge CLK);
    total++;
    if (obsn8.size() != 1000) begin bad++; $display("FAIL div_count got=%0d want=1000", obsn8.size()); end
    for (int i = 0; i < 1000 && i < obsn8.size(); i++) begin
      total++;
      if (obsn8[i] !== exp8[i]) begin bad++; $display("FAIL div_num[%0d] got=%h want=%h", i, obsn8[i], exp8[i]); end
      total++;
      if (obsc8[i] - iss8[i] != 10) begin bad++; $display("FAIL div_latency[%0d] got=%0d want=10", i, obsc8[i] - iss8[i]); end
`ifdef RECON_OVF_CHECK_EN
      total++;
      if (obso8[i] !== 1'b0) begin bad++; $display("FAIL div_ovf[%0d] got=%b want=0", i, obso8[i]); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flush();
    test_divider_loop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
